// File: rtl/dnu_hd_frame_packer_pkg.sv
// Shared sizing constants and output FSM encoding for the DNU hard-decision frame packer.
package dnu_hd_frame_packer_pkg;
   localparam int VN_NUM          = 204;
   localparam int LANE_NUM        = 4;
   localparam int MULTI_FRAME_NUM = 2;
   localparam int SEG_NUM         = VN_NUM / LANE_NUM;
   localparam int SEG_CNT_W       = $clog2(SEG_NUM);

   typedef enum logic {
      HDP_IDLE = 1'b0,
      HDP_HOLD = 1'b1
   } hdp_state_e;
endpackage

// File: rtl/dnu_hd_frame_packer_slot.sv
// One assembly slot: collects LANE_NUM-bit segments into a VN_NUM-bit vector and flags
// completion; frame_o presents the buffer including this cycle's write for same-edge loading.
module dnu_hd_frame_packer_slot
   import dnu_hd_frame_packer_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                clear_i,
   input  logic                wr_en_i,
   input  logic [LANE_NUM-1:0] wr_bits_i,
   input  logic                take_i,
   output logic                full_o,
   output logic                done_o,
   output logic                overflow_o,
   output logic [VN_NUM-1:0]   frame_o
);
   logic [SEG_CNT_W-1:0] cnt_q, cnt_d;
   logic                 full_q, full_d;
   logic [VN_NUM-1:0]    buf_q, buf_d;
   logic                 accept_s;

   // Segment write, counter wrap and full-flag bookkeeping; clear outranks everything.
   always_comb begin
      accept_s = wr_en_i & ~full_q & ~clear_i;
      done_o   = accept_s & (cnt_q == SEG_CNT_W'(SEG_NUM - 1));
      buf_d    = buf_q;
      cnt_d    = cnt_q;
      if (accept_s) begin
         buf_d[LANE_NUM*cnt_q +: LANE_NUM] = wr_bits_i;
         cnt_d = done_o ? '0 : cnt_q + SEG_CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
      full_d = (full_q | done_o) & ~take_i;
      if (clear_i) begin
         cnt_d  = '0;
         full_d = 1'b0;
      end else begin
         full_d = full_d;
      end
   end

   assign full_o     = full_q;
   assign overflow_o = wr_en_i & full_q & ~clear_i;
   assign frame_o    = buf_d;

   // Slot state registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         full_q <= 1'b0;
         buf_q  <= '0;
      end else begin
         cnt_q  <= cnt_d;
         full_q <= full_d;
         buf_q  <= buf_d;
      end
   end
endmodule

// File: rtl/dnu_hd_frame_packer.sv
// Packs the four DNU f0 hard-decision lanes into per-slot codeword vectors and hands each
// finished vector out through a valid/ready output register.
module dnu_hd_frame_packer
   import dnu_hd_frame_packer_pkg::*;
(
   input  logic              read_clk,
   input  logic              rst,
   input  logic              dnu0_hard_decision,
   input  logic              dnu1_hard_decision,
   input  logic              dnu2_hard_decision,
   input  logic              dnu3_hard_decision,
   input  logic              hd_valid_in,
   input  logic              hd_frame_sel,
   input  logic              iter_clear,
   input  logic              hd_frame_ready,
   output logic              hd_frame_valid,
   output logic [VN_NUM-1:0] hd_frame_data,
   output logic              hd_frame_id,
   output logic              overflow_err
);
   logic [MULTI_FRAME_NUM-1:0] wr_en_s, full_s, done_s, ovf_s, take_s, avail_s;
   logic [VN_NUM-1:0]          frame_s [MULTI_FRAME_NUM];
   logic [LANE_NUM-1:0]        lanes_s;
   hdp_state_e                 state_q, state_d;
   logic [VN_NUM-1:0]          data_q, data_d;
   logic                       id_q, id_d;
   logic                       ovf_q, ovf_d;

   assign lanes_s = {dnu3_hard_decision, dnu2_hard_decision, dnu1_hard_decision, dnu0_hard_decision};
   assign avail_s = full_s | done_s;

   for (genvar g = 0; g < MULTI_FRAME_NUM; g++) begin : g_slot
      assign wr_en_s[g] = hd_valid_in & (hd_frame_sel == 1'(g));

      dnu_hd_frame_packer_slot u_slot (
         .clk_i      (read_clk),
         .rst_i      (rst),
         .clear_i    (iter_clear),
         .wr_en_i    (wr_en_s[g]),
         .wr_bits_i  (lanes_s),
         .take_i     (take_s[g]),
         .full_o     (full_s[g]),
         .done_o     (done_s[g]),
         .overflow_o (ovf_s[g]),
         .frame_o    (frame_s[g])
      );
   end

   // Output FSM: lowest-index complete slot wins; iter_clear drops any pending vector.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      id_d    = id_q;
      take_s  = '0;
      ovf_d   = ovf_q | (|ovf_s);
      case (state_q)
         HDP_IDLE: begin
            if (avail_s[0]) begin
               data_d    = frame_s[0];
               id_d      = 1'b0;
               take_s[0] = 1'b1;
               state_d   = HDP_HOLD;
            end else if (avail_s[1]) begin
               data_d    = frame_s[1];
               id_d      = 1'b1;
               take_s[1] = 1'b1;
               state_d   = HDP_HOLD;
            end else begin
               state_d = HDP_IDLE;
            end
         end
         HDP_HOLD: begin
            if (hd_frame_ready) begin
               state_d = HDP_IDLE;
            end else begin
               state_d = HDP_HOLD;
            end
         end
         default: state_d = HDP_IDLE;
      endcase
      if (iter_clear) begin
         state_d = HDP_IDLE;
         take_s  = '0;
         ovf_d   = 1'b0;
      end else begin
         ovf_d = ovf_d;
      end
   end

   // Output register and sticky overflow flag.
   always_ff @(posedge read_clk or posedge rst) begin
      if (rst) begin
         state_q <= HDP_IDLE;
         data_q  <= '0;
         id_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         id_q    <= id_d;
         ovf_q   <= ovf_d;
      end
   end

   assign hd_frame_valid = (state_q == HDP_HOLD);
   assign hd_frame_data  = data_q;
   assign hd_frame_id    = id_q;
   assign overflow_err   = ovf_q;
endmodule
